// File: rtl/bus_ram_if.sv
// bus_ram_if: valid/ready memory bus between a CPU-side master and a word RAM slave.
// Latency: none, signal bundle only.
// Backpressure: master holds valid/addr/wstrb/wdata stable until the slave pulses ready.
interface bus_ram_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata, err
  );
endinterface

// File: rtl/bus_ram.sv
// bus_ram: single-port word RAM with base-address decode, error response, read wait states, write protect.
// Latency: ready LATENCY (1-4) cycles after acceptance; one transfer per LATENCY+1 cycles.
// Backpressure: a request is accepted only in IDLE; valid is ignored until the ready strobe.
// Optional feature macro BUS_RAM_STATS_EN: saturating accepted-read / committed-write counters.
module bus_ram #(
  parameter int unsigned WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  bus_ram_if.slave    bus,
  input  logic        wp,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int unsigned AW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  logic [29:0]   woff;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          is_wr;
  logic          accept;
  logic          do_write;
  logic          unused_addr;

  // BASE_ADDR is word aligned, so the word offset is the difference of the word fields;
  // this equals (addr - BASE_ADDR)[31:2] including the 32-bit wrap.
  assign woff        = bus.addr[31:2] - BASE_ADDR[31:2];
  assign in_range    = {2'b00, woff} < WORDS;
  assign idx         = woff[AW-1:0];
  assign is_wr       = |bus.wstrb;
  assign accept      = (state_q == IDLE) && bus.valid && !reset;
  assign do_write    = accept && in_range && is_wr && !wp;
  assign unused_addr = ^bus.addr[1:0];

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

  // state register and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: accept in IDLE, count down wait states, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          cnt_d   = 2'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: ready is a one-cycle strobe in RESP
  always_comb begin
    bus.ready = 1'b0;
    if (state_q == RESP) begin
      bus.ready = 1'b1;
    end
  end

  // byte-lane write commit on the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // response capture at acceptance: old word (pre-write) or zero when out of range
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= in_range ? mem[idx] : 32'h0;
      err_q   <= !in_range || (is_wr && wp);
    end
  end

`ifdef BUS_RAM_STATS_EN
  logic [31:0] rd_q;
  logic [31:0] wr_q;

  // saturating counters of accepted in-range reads and committed writes
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 32'h0;
      wr_q <= 32'h0;
    end else begin
      if (accept && in_range && !is_wr && (rd_q != 32'hFFFF_FFFF)) begin
        rd_q <= rd_q + 32'd1;
      end
      if (do_write && (wr_q != 32'hFFFF_FFFF)) begin
        wr_q <= wr_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;
`else
  assign rd_count = 32'h0;
  assign wr_count = 32'h0;
`endif

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: checks three bus_ram configurations against a word-array reference model.
// Latency: measures ready latency per transfer against LATENCY.
// Backpressure: drives valid held until ready, dropped right after, back-to-back requests.
module tb_bus_ram;
  localparam int          LAT_P   [3] = '{1, 3, 4};
  localparam int          WORDS_P [3] = '{256, 256, 16};
  localparam logic [31:0] BASE_P  [3] = '{32'h0000_0000, 32'h0100_0000, 32'h0000_8000};
`ifdef BUS_RAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [2:0]  rst;
  logic [2:0]  vld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wp;
  logic [2:0]  rdy;
  logic [2:0]  er;
  logic [31:0] rdat [3];
  logic [31:0] rdc  [3];
  logic [31:0] wrc  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_ram_if bif0 ();
  bus_ram_if bif1 ();
  bus_ram_if bif2 ();

  assign bif0.valid = vld[0]; assign bif0.addr = addr; assign bif0.wstrb = wstrb; assign bif0.wdata = wdata;
  assign bif1.valid = vld[1]; assign bif1.addr = addr; assign bif1.wstrb = wstrb; assign bif1.wdata = wdata;
  assign bif2.valid = vld[2]; assign bif2.addr = addr; assign bif2.wstrb = wstrb; assign bif2.wdata = wdata;
  assign rdy[0] = bif0.ready; assign rdat[0] = bif0.rdata; assign er[0] = bif0.err;
  assign rdy[1] = bif1.ready; assign rdat[1] = bif1.rdata; assign er[1] = bif1.err;
  assign rdy[2] = bif2.ready; assign rdat[2] = bif2.rdata; assign er[2] = bif2.err;

  bus_ram #(.WORDS(256), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u0 (
    .clk(clk), .reset(rst[0]), .bus(bif0), .wp(wp), .rd_count(rdc[0]), .wr_count(wrc[0]));
  bus_ram #(.WORDS(256), .BASE_ADDR(32'h0100_0000), .LATENCY(3)) u1 (
    .clk(clk), .reset(rst[1]), .bus(bif1), .wp(wp), .rd_count(rdc[1]), .wr_count(wrc[1]));
  bus_ram #(.WORDS(16), .BASE_ADDR(32'h0000_8000), .LATENCY(4)) u2 (
    .clk(clk), .reset(rst[2]), .bus(bif2), .wp(wp), .rd_count(rdc[2]), .wr_count(wrc[2]));

  // reference model: plain word arrays plus knowledge of which words hold defined data
  logic [31:0] mdl   [3][256];
  bit          known [3][256];
  int          m_rd  [3];
  int          m_wr  [3];
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    bit          p;
    logic [31:0] erd;
    bit          ee;
    bit          crd;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                     input bit p, output logic [31:0] rd, output logic e, output int lat);
    addr = a; wstrb = s; wdata = wd; wp = p;
    vld[d] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rdy[d] && lat < 20);
    if (!rdy[d]) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout dut%0d: ready absent after %0d cycles", d, lat);
    end
    rd = rdat[d];
    e  = er[d];
    vld[d] = 1'b0;
  endtask

  // one transfer checked against the model; returns in the cycle after ready
  task automatic run(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                     input bit p, output logic [31:0] rd, output logic e);
    logic [31:0] off;
    logic [31:0] mask;
    logic [31:0] exp_rd;
    bit          inr;
    bit          exp_e;
    bit          rd_known;
    int          ix;
    int          lat;
    off      = a - BASE_P[d];
    inr      = (off >> 2) < WORDS_P[d];
    ix       = inr ? int'(off >> 2) : 0;
    exp_e    = !inr || ((s != 4'h0) && p);
    exp_rd   = inr ? mdl[d][ix] : 32'h0;
    rd_known = !inr || known[d][ix];
    req(d, a, s, wd, p, rd, e, lat);
    chk($sformatf("latency dut%0d", d), lat, LAT_P[d]);
    chk($sformatf("err dut%0d addr %h", d, a), 32'(e), 32'(exp_e));
    if (rd_known) chk($sformatf("rdata dut%0d addr %h", d, a), rd, exp_rd);
    if (inr && (s == 4'h0)) m_rd[d]++;
    if (inr && (s != 4'h0) && !p) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      mdl[d][ix]   = (mdl[d][ix] & ~mask) | (wd & mask);
      known[d][ix] = known[d][ix] || (s == 4'hF);
      m_wr[d]++;
    end
    chk($sformatf("rd_count dut%0d", d), rdc[d], STATS ? 32'(m_rd[d]) : 32'h0);
    chk($sformatf("wr_count dut%0d", d), wrc[d], STATS ? 32'(m_wr[d]) : 32'h0);
    tick();
    chk($sformatf("ready strobe dut%0d", d), 32'(rdy[d]), 32'h0);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    tick();
    tick();
    rst[d] = 1'b0;
    m_rd[d] = 0;
    m_wr[d] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          r1, r2, extra;
    int          d, k;
    logic [31:0] a;
    logic [3:0]  s;

    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 0;
      m_wr[i] = 0;
      for (int j = 0; j < 256; j++) begin
        mdl[i][j]   = 32'h0;
        known[i][j] = 1'b0;
      end
    end

    //               d  addr           wstrb  wdata          wp  exp rdata      err chk_rd
    tbl[0]  = '{0, 32'h0000_0010, 4'hF, 32'hA5A5_1234, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[1]  = '{0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hA5A5_1234, 1'b0, 1'b1};
    tbl[2]  = '{0, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[3]  = '{0, 32'h0000_0020, 4'h5, 32'hFFFF_FFFF, 1'b0, 32'h1122_3344, 1'b0, 1'b1};
    tbl[4]  = '{0, 32'h0000_0022, 4'h0, 32'h0,         1'b0, 32'h11FF_33FF, 1'b0, 1'b1};
    tbl[5]  = '{1, 32'h0100_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1, 32'h0100_0400, 4'h0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};
    tbl[7]  = '{1, 32'h00FF_FFFC, 4'h0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};
    tbl[8]  = '{1, 32'h0100_0000, 4'hF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1};
    tbl[9]  = '{1, 32'h0100_0000, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[10] = '{1, 32'h0100_03FC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[11] = '{1, 32'h0100_03FC, 4'h0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 1'b1};
    tbl[12] = '{1, 32'h0100_0400, 4'hF, 32'h5555_AAAA, 1'b0, 32'h0,         1'b1, 1'b1};
    tbl[13] = '{2, 32'h0000_803C, 4'hF, 32'h0BAD_CAFE, 1'b0, 32'h0,         1'b0, 1'b0};
    tbl[14] = '{2, 32'h0000_8040, 4'h0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};
    tbl[15] = '{2, 32'h0000_803C, 4'h0, 32'h0,         1'b0, 32'h0BAD_CAFE, 1'b0, 1'b1};
    tbl[16] = '{2, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};

    rst = 3'b111; vld = 3'b000; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0; wp = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ready dut%0d", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("reset rdata dut%0d", i), rdat[i], 32'h0);
      chk($sformatf("reset err dut%0d", i), 32'(er[i]), 32'h0);
      chk($sformatf("reset rd_count dut%0d", i), rdc[i], 32'h0);
      chk($sformatf("reset wr_count dut%0d", i), wrc[i], 32'h0);
    end
    rst = 3'b000;

    // directed vectors
    for (int i = 0; i < 17; i++) begin
      run(tbl[i].d, tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].p, rd, e);
      chk($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].ee));
      if (tbl[i].crd) chk($sformatf("vec%0d rdata", i), rd, tbl[i].erd);
    end

    // back-to-back reads on LATENCY=3: ready spacing of LATENCY+1 cycles
    run(1, 32'h0100_0000, 4'h0, 32'h0, 1'b0, rd, e);
    r1 = cyc;
    run(1, 32'h0100_0000, 4'h0, 32'h0, 1'b0, rd, e);
    r2 = cyc;
    chk("back-to-back spacing", 32'(r2 - r1), 32'd4);

    // valid pulses during WAIT produce no extra ready
    addr = 32'h0100_0000; wstrb = 4'h0; wp = 1'b0;
    vld[1] = 1'b1;
    tick(); vld[1] = 1'b0; chk("pulse ready t0+1", 32'(rdy[1]), 32'h0);
    tick(); vld[1] = 1'b1; chk("pulse ready t0+2", 32'(rdy[1]), 32'h0);
    tick(); vld[1] = 1'b0; chk("pulse ready t0+3", 32'(rdy[1]), 32'h1);
    chk("pulse rdata", rdat[1], 32'hDEAD_BEEF);
    m_rd[1]++;
    extra = 0;
    repeat (6) begin tick(); if (rdy[1]) extra++; end
    chk("pulse extra ready", 32'(extra), 32'h0);

    // reset mid-operation on LATENCY=4 after a committed write
    addr = 32'h0000_8010; wstrb = 4'hF; wdata = 32'h5A5A_0F0F; wp = 1'b0;
    vld[2] = 1'b1;
    tick(); vld[2] = 1'b0; chk("midreset ready t0+1", 32'(rdy[2]), 32'h0);
    tick(); rst[2] = 1'b1; chk("midreset ready t0+2", 32'(rdy[2]), 32'h0);
    tick(); rst[2] = 1'b0;
    chk("midreset ready", 32'(rdy[2]), 32'h0);
    chk("midreset rdata", rdat[2], 32'h0);
    chk("midreset err", 32'(er[2]), 32'h0);
    chk("midreset rd_count", rdc[2], 32'h0);
    chk("midreset wr_count", wrc[2], 32'h0);
    mdl[2][4] = 32'h5A5A_0F0F; known[2][4] = 1'b1;
    m_rd[2] = 0; m_wr[2] = 0;
    extra = 0;
    repeat (8) begin tick(); if (rdy[2]) extra++; end
    chk("midreset no ready", 32'(extra), 32'h0);
    run(2, 32'h0000_8010, 4'h0, 32'h0, 1'b0, rd, e);
    chk("midreset write kept", rd, 32'h5A5A_0F0F);

    // reset together with valid: request not accepted, no write
    addr = 32'h0000_8010; wstrb = 4'hF; wdata = 32'h0; wp = 1'b0;
    rst[2] = 1'b1; vld[2] = 1'b1;
    tick(); rst[2] = 1'b0; vld[2] = 1'b0;
    m_rd[2] = 0; m_wr[2] = 0;
    extra = 0;
    repeat (6) begin tick(); if (rdy[2]) extra++; end
    chk("reset+valid no ready", 32'(extra), 32'h0);
    run(2, 32'h0000_8010, 4'h0, 32'h0, 1'b0, rd, e);
    chk("reset+valid no write", rd, 32'h5A5A_0F0F);

    // randomized traffic over a preloaded word set plus out-of-range addresses
    for (int dd = 0; dd < 2; dd++)
      for (int kk = 0; kk < 8; kk++)
        run(dd, BASE_P[dd] + 32'(kk * 132), 4'hF, $urandom, 1'b0, rd, e);
    for (int it = 0; it < 200; it++) begin
      d = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 7));
      a = BASE_P[d] + 32'(k * 132) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a = BASE_P[d] + 32'((WORDS_P[d] + int'($urandom_range(0, 100))) * 4);
        1: a = BASE_P[d] - 32'((1 + int'($urandom_range(0, 100))) * 4);
        default: ;
      endcase
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      run(d, a, s, $urandom, ($urandom_range(0, 3) == 0), rd, e);
    end

    // statistics scenario on a freshly reset instance
    do_reset(1);
    run(1, 32'h0100_0010, 4'hF, 32'h0000_0001, 1'b0, rd, e);
    run(1, 32'h0100_0014, 4'hF, 32'h0000_0002, 1'b0, rd, e);
    run(1, 32'h0100_0000, 4'h0, 32'h0, 1'b0, rd, e);
    run(1, 32'h0100_0010, 4'h0, 32'h0, 1'b0, rd, e);
    run(1, 32'h0100_0014, 4'h0, 32'h0, 1'b0, rd, e);
    run(1, 32'h0100_0800, 4'h0, 32'h0, 1'b0, rd, e);
    run(1, 32'h0100_0010, 4'hF, 32'hFFFF_FFFF, 1'b1, rd, e);
    chk("stats rd_count", rdc[1], STATS ? 32'd3 : 32'd0);
    chk("stats wr_count", wrc[1], STATS ? 32'd2 : 32'd0);
    do_reset(1);
    chk("stats rd_count cleared", rdc[1], 32'h0);
    chk("stats wr_count cleared", wrc[1], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port word RAM on the native `valid`/`ready` memory bus. It is the successor to the fixed-latency boot ROM/RAM. It adds:
- a programmable base address with out-of-range detection and an error response,
- configurable read wait states (1–4 cycles),
- a write-protect input.

It sits behind the bus decoder next to the peripherals and serves instruction and data traffic from the CPU.

## Interface
- `WORDS`, 256, depth in 32-bit words; any value ≥ 2; index width `AW = $clog2(WORDS)`
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- `LATENCY`, 1, cycles from request acceptance to `ready`; legal range 1–4
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `valid`  in  1  request present; held with `addr`/`wstrb`/`wdata` stable until `ready`
- `ready`  out  1  one-cycle response strobe
- `wstrb`  in  4  byte write enables; 4'b0000 is a read
- `addr`  in  32  byte address; `addr[1:0]` ignored
- `wdata`  in  32  write data, byte lanes per `wstrb`
- `rdata`  out  32  read data, valid while `ready` is high
- `err`  out  1  error flag, valid while `ready` is high
- `wp`  in  1  write protect, sampled at acceptance
- `rd_count`  out  32  accepted in-range read count (see Configuration)
- `wr_count`  out  32  committed write count (see Configuration)

## Operation
- **Offset.** `off = addr - BASE_ADDR` (32-bit wrap). The request is in range iff `off[31:2] < WORDS`. Word index = `off[AW+1:2]`.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE.** If `valid`=1, the request is accepted this cycle; the FSM loads the wait counter with `LATENCY-1` and goes to WAIT, or directly to RESP when `LATENCY`=1.
- **WAIT.** Counter decrements each cycle. At 1 the FSM goes to RESP. `valid` is ignored.
- **RESP.** `ready`=1 for exactly this cycle, then IDLE.
- **Write commit.** Happens on the edge ending the acceptance cycle. Only lanes with `wstrb[i]`=1 are written, and only if the request is in range and `wp`=0.
- **Read capture.**
  - `rdata` is the word's contents before any write by the same request.
  - It is captured on the edge ending the acceptance cycle and held until the next `ready`.
- **`err` = 1 with `ready` when:**
  - the request is out of range: no write occurs, `rdata`=0;
  - `wstrb`≠0 and `wp`=1: no write occurs, `rdata` = old word.
- **Otherwise** `err`=0.
- **Reads** (`wstrb`=0) never raise `err` because of `wp`.
- **Back-to-back.** The master must drop `valid` in the cycle after `ready` unless it is issuing a new request. A `valid` seen in IDLE is always treated as a new request.
- **Memory contents** are not initialised and are never cleared by reset.

## Timing
- **Reset values:** state IDLE, `ready`=0, `rdata`=32'h0, `err`=0, `rd_count`=0, `wr_count`=0.
- **Latency.** Request accepted in cycle t0 gives `ready` in cycle t0+`LATENCY`, with `rdata`/`err` valid in that cycle.
- **Throughput.** One transfer per `LATENCY`+1 cycles; the next acceptance is earliest at t0+`LATENCY`+1.
- **Reset mid-operation.**
  - Any state goes to IDLE the next cycle and the pending `ready` is not issued.
  - A write already committed at acceptance stays committed.
- **`reset` and `valid` together.** Reset wins; the request is not accepted.

## Configuration
- `BUS_RAM_STATS_EN` defined:
  - `rd_count` increments by 1 on each accepted in-range read.
  - `wr_count` increments by 1 on each committed write.
  - Both update on the acceptance edge, saturate at 32'hFFFF_FFFF, and clear on `reset`.
- Not defined: both counters are tied to 0 and no counter flops are synthesised.

## Test plan
1. **Basic write/read.** `LATENCY`=1, `BASE_ADDR`=0:
   - write 32'hA5A5_1234 to 0x10, `wstrb`=4'hF → `ready` at t0+1, `err`=0;
   - read 0x10 → `rdata`=32'hA5A5_1234.
2. **Byte lanes.**
   - Preload word 0x20 = 32'h1122_3344.
   - Write `wdata`=32'hFFFF_FFFF with `wstrb`=4'b0101.
   - Read back → 32'h11FF_33FF; the write's own `rdata` = 32'h1122_3344.
3. **Wait states.** `LATENCY`=3, back-to-back reads with `valid` re-asserted the cycle after `ready`:
   - `ready` at t0+3 and t0+7;
   - `valid` pulses held during WAIT produce no extra `ready`.
4. **Range and protect.** `BASE_ADDR`=32'h0100_0000, `WORDS`=256:
   - read 32'h0100_0400 → `err`=1, `rdata`=0;
   - read 32'h00FF_FFFC → `err`=1, `rdata`=0;
   - write to 32'h0100_0000 with `wp`=1 → `err`=1, word unchanged on re-read.
5. **Reset mid-op.** `LATENCY`=4:
   - assert `reset` at t0+2 → no `ready` ever appears for that request;
   - outputs are at reset values the next cycle;
   - a write accepted at t0 is visible on a later read.
6. **Stats** (`BUS_RAM_STATS_EN`):
   - 3 in-range reads, 1 out-of-range read, 2 writes, 1 protected write → `rd_count`=3, `wr_count`=2;
   - after `reset`, both are 0.
